freq_counter_multi: RTL and testbench
=====================================

Name: freq_counter_multi

Overview:
Multi-channel frequency counter peripheral. It is the parametrised successor of the single-channel freqCounter0 in the Hydrogen SoC. It counts rising edges on CHANNELS asynchronous input signals during a shared, programmable gate window of io_clock cycles. Per-channel results are then emitted serially over a valid/ready stream that the bus bridge (APB register file) consumes; the bridge is outside this block. Single-shot and continuous modes are supported.

Parameters:
CHANNELS, 4, number of measured inputs (1..16)
COUNT_WIDTH, 32, edge counter width per channel
GATE_WIDTH, 32, gate length register width
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
io_clock  input  1  system clock; the only clock in the block
io_reset_n  input  1  asynchronous active-low reset
io_channels  input  CHANNELS  asynchronous signals to measure
io_enable  input  1  block enable; deassert aborts any measurement
io_continuous  input  1  1 = re-arm automatically after drain
io_start  input  1  single-cycle start pulse
io_gate_cycles  input  GATE_WIDTH  gate length in io_clock cycles
io_busy  output  1  high in MEASURE or DRAIN
io_result_valid  output  1  result stream valid
io_result_ready  input  1  result stream ready
io_result_channel  output  CH_W  channel index, CH_W = max(1,clog2(CHANNELS))
io_result_count  output  COUNT_WIDTH  rising edges counted in the gate
io_result_overflow  output  1  counter saturated during the gate

Behaviour:
- Reset (async assert, sync deassert via io_clock): FSM=IDLE. All counters, synchroniser flops and outputs are 0: io_busy=0, io_result_valid=0, io_result_channel=0, io_result_count=0, io_result_overflow=0.
- Input path per channel: SYNC_STAGES flops, then an edge register. Rising edge = sync & ~prev. Input-to-edge latency is SYNC_STAGES+1 cycles. Guaranteed accurate only for input frequency < io_clock/2.
- FSM states:
  - IDLE: waits for io_start & io_enable. On start, latches gate = max(io_gate_cycles,1), clears all counters and overflow flags, then goes to MEASURE.
  - MEASURE: gate counter counts down once per cycle; every cycle, each channel counter increments on an edge. Exactly gate cycles are sampled, including an edge on the last cycle. After the last sample, goes to DRAIN with index=0.
  - DRAIN: presents channel[index] with valid=1. On valid&ready, index increments. After the transfer with index=CHANNELS-1: if io_continuous & io_enable, go to MEASURE (re-latch io_gate_cycles, clear counters, no idle cycle); else go to IDLE.
- Stream rules: valid never drops without a handshake except on abort. Channel, count and overflow stay stable while valid & ~ready. Edges during DRAIN and IDLE are not counted.
- Saturation: a counter at all-ones does not wrap. Its overflow flag is set and held until the next measurement start.
- io_start while busy is ignored. io_gate_cycles changes during MEASURE have no effect.
- io_enable=0 in any state: next cycle FSM=IDLE, valid=0, counters cleared, no results emitted. io_enable=0 takes priority over a simultaneous io_start.
- io_busy=1 exactly when FSM is MEASURE or DRAIN.

Decomposition:
- Package freq_counter_pkg holds:
  - state_t enum {IDLE, MEASURE, DRAIN}
  - result_t struct {channel, count, overflow}
  - function ch_width(CHANNELS)
- Sub-module freq_sync_edge (parameter SYNC_STAGES): one synchroniser plus rising-edge detector, instantiated CHANNELS times via generate.

Test Plan:
- Channel 0 at period 4 clocks, gate 100, ready=1 -> one measurement; results ch0 count=25 then ch1..3 count=0, overflow=0; io_busy falls after the 4th handshake.
- COUNT_WIDTH=4, channel 1 at period 2 clocks, gate 40 -> ch1 count=15, overflow=1; next measurement with input idle -> count=0, overflow=0.
- Gate 0 with channel 2 edge on every possible cycle -> treated as gate 1; count is 0 or 1, never more; exactly CHANNELS results.
- ready held low 10 cycles during DRAIN -> valid stays 1 and channel/count/overflow unchanged; order of results is 0,1,2,3.
- io_continuous=1, gate 50, channel 3 at period 5 -> back-to-back result groups each with ch3 count=10, no IDLE cycle between groups; clearing io_continuous ends after the current group.
- io_enable dropped mid-MEASURE, and separately io_reset_n asserted mid-DRAIN -> next cycle valid=0, busy=0. A following start yields fresh counts with no stale values.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and helpers for the multi-channel frequency counter.
package freq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Widest configuration supported: 16 channels, 64-bit counters.
  localparam int MAX_CH_W    = 4;
  localparam int MAX_COUNT_W = 64;

  typedef struct packed {
    logic [MAX_CH_W-1:0]    channel;
    logic [MAX_COUNT_W-1:0] count;
    logic                   overflow;
  } result_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_width(input int channels);
    int w;
    w = $clog2(channels);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/freq_sync_edge.sv
// Synchroniser chain plus rising-edge detector for one asynchronous input.
module freq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the input through the synchroniser and keep the previous synced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_counter_multi.sv
// Multi-channel frequency counter: counts input rising edges over a shared
// gate window and streams one result per channel over valid/ready.
module freq_counter_multi
  import freq_counter_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  COUNT_WIDTH = 32,
  parameter int  GATE_WIDTH  = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = ch_width(CHANNELS)
) (
  input  logic                   io_clock,
  input  logic                   io_reset_n,
  input  logic [CHANNELS-1:0]    io_channels,
  input  logic                   io_enable,
  input  logic                   io_continuous,
  input  logic                   io_start,
  input  logic [GATE_WIDTH-1:0]  io_gate_cycles,
  output logic                   io_busy,
  output logic                   io_result_valid,
  input  logic                   io_result_ready,
  output logic [CH_W-1:0]        io_result_channel,
  output logic [COUNT_WIDTH-1:0] io_result_count,
  output logic                   io_result_overflow
);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  state_t                 state_q, state_d;
  logic [GATE_WIDTH-1:0]  gate_q;
  logic [GATE_WIDTH-1:0]  gate_load;
  logic [CH_W-1:0]        idx_q;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0]    ovf_q;
  logic [CHANNELS-1:0]    rise;
  logic                   handshake, last_idx, gate_last, arm;

  // Reset asserts immediately and releases two clocks after io_reset_n rises.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_in
    freq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (io_clock),
      .rst_ni (rst_n),
      .async_i(io_channels[c]),
      .rise_o (rise[c])
    );
  end

  assign handshake = (state_q == DRAIN) & io_result_ready;
  assign last_idx  = (idx_q == CH_W'(CHANNELS - 1));
  assign gate_last = (gate_q == GATE_WIDTH'(1));
  assign gate_load = (io_gate_cycles == '0) ? GATE_WIDTH'(1) : io_gate_cycles;
  // A new measurement starts from IDLE on start, or straight out of the final
  // drain transfer when running continuously.
  assign arm = io_enable & (((state_q == IDLE) & io_start) |
                            (handshake & last_idx & io_continuous));

  // State register.
  always_ff @(posedge io_clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping enable returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!io_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (io_start) state_d = MEASURE;
        MEASURE: if (gate_last) state_d = DRAIN;
        DRAIN:   if (handshake && last_idx) state_d = io_continuous ? MEASURE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Gate countdown, drain index and saturating per-channel edge counters.
  always_ff @(posedge io_clock or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      idx_q  <= '0;
      ovf_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      if (arm)                     gate_q <= gate_load;
      else if (state_q == MEASURE) gate_q <= gate_q - GATE_WIDTH'(1);

      if (state_q != DRAIN || !io_enable) idx_q <= '0;
      else if (handshake)                 idx_q <= last_idx ? '0 : idx_q + CH_W'(1);

      for (int c = 0; c < CHANNELS; c++) begin
        if (arm || !io_enable) begin
          cnt_q[c] <= '0;
          ovf_q[c] <= 1'b0;
        end else if (state_q == MEASURE && rise[c]) begin
          if (&cnt_q[c]) ovf_q[c] <= 1'b1;
          else           cnt_q[c] <= cnt_q[c] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Outputs: result fields are zero whenever no result is offered.
  always_comb begin
    io_busy            = (state_q != IDLE);
    io_result_valid    = 1'b0;
    io_result_channel  = '0;
    io_result_count    = '0;
    io_result_overflow = 1'b0;
    if (state_q == DRAIN) begin
      io_result_valid    = 1'b1;
      io_result_channel  = idx_q;
      io_result_count    = cnt_q[idx_q];
      io_result_overflow = ovf_q[idx_q];
    end
  end

endmodule

// File: tb/tb_freq_counter_multi.sv
// Randomized self-checking bench for freq_counter_multi with an edge-counting
// reference model driven from the recorded input history.
module tb_freq_counter_multi;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int GW = 16;
  localparam int SS = 2;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cont = 1'b0;
  logic          start = 1'b0;
  logic          rdy = 1'b0;
  logic [CH-1:0] chans = '0;
  logic [GW-1:0] gate = '0;
  logic          busy, vld, ovf;
  logic [1:0]    rch;
  logic [CW-1:0] rcnt;

  always #5 clk = ~clk;

  freq_counter_multi #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(SS)
  ) dut (
    .io_clock(clk), .io_reset_n(rst_n), .io_channels(chans), .io_enable(en),
    .io_continuous(cont), .io_start(start), .io_gate_cycles(gate),
    .io_busy(busy), .io_result_valid(vld), .io_result_ready(rdy),
    .io_result_channel(rch), .io_result_count(rcnt), .io_result_overflow(ovf)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [CH-1:0] hist[$];
  int per[CH];     // 0 = held low, 1 = random level each cycle, >=2 = square wave period
  int phase[CH];
  longint exp_cnt[CH];
  longint exp_ovf[CH];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; new input levels are applied 1 time unit after the edge.
  task automatic step();
    logic [CH-1:0] v;
    @(posedge clk);
    #1;
    cyc++;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      if (per[c] == 1)      v[c] = 1'($urandom_range(0, 1));
      else if (per[c] >= 2) v[c] = (((cyc + phase[c]) % per[c]) < (per[c] / 2));
    end
    chans = v;
    hist.push_back(v);
  endtask

  function automatic bit bitat(input int i, input int c);
    if (i < 0 || i >= hist.size()) return 1'b0;
    return hist[i][c];
  endfunction

  // Measurement started by a start/re-arm in cycle a samples cycles a+1..a+g;
  // an input rise between cycles n-1 and n is seen in cycle n+SS.
  task automatic model(input int a, input int g);
    int ge;
    longint e;
    ge = (g == 0) ? 1 : g;
    for (int c = 0; c < CH; c++) begin
      e = 0;
      for (int t = a + 1; t <= a + ge; t++)
        if (bitat(t - SS, c) && !bitat(t - SS - 1, c)) e++;
      exp_cnt[c] = (e > MAXC) ? MAXC : e;
      exp_ovf[c] = (e > MAXC) ? 1 : 0;
    end
  endtask

  task automatic start_meas(input int g, output int a);
    gate = GW'(g);
    start = 1'b1;
    a = cyc;
    step();
    start = 1'b0;
    gate = GW'($urandom_range(0, 65535));
  endtask

  // Runs one measurement from cycle a+1 through its drain. stall_k selects the
  // channel whose handshake is delayed by 10 cycles; h returns the cycle of
  // the final handshake.
  task automatic run_group(input int a, input int g, input int stall_k, input bit poke,
                           input bit cont_next, input int g_next, output int h);
    int ge, hold;
    ge = (g == 0) ? 1 : g;
    h = cyc;
    check_eq("busy_first", longint'(busy), 1);
    while (cyc < a + ge) begin
      step();
      start = poke && (cyc == a + 1);
    end
    start = 1'b0;
    check_eq("busy_last_meas", longint'(busy), 1);
    check_eq("vld_last_meas", longint'(vld), 0);
    gate = GW'(g_next);
    cont = cont_next;
    step();
    model(a, g);
    for (int k = 0; k < CH; k++) begin
      hold = (k == stall_k) ? 10 : $urandom_range(0, 2);
      rdy = 1'b0;
      for (int s = 0; s < hold; s++) begin
        check_eq("vld_stall", longint'(vld), 1);
        check_eq("ch_stall", longint'(rch), k);
        check_eq("cnt_stall", longint'(rcnt), exp_cnt[k]);
        check_eq("ovf_stall", longint'(ovf), exp_ovf[k]);
        step();
      end
      rdy = 1'b1;
      check_eq("vld", longint'(vld), 1);
      check_eq("ch", longint'(rch), k);
      check_eq("cnt", longint'(rcnt), exp_cnt[k]);
      check_eq("ovf", longint'(ovf), exp_ovf[k]);
      h = cyc;
      step();
      rdy = 1'b0;
    end
    if (cont_next) check_eq("busy_rearm", longint'(busy), 1);
    else           check_eq("busy_done", longint'(busy), 0);
    check_eq("vld_after", longint'(vld), 0);
  endtask

  task automatic set_idle();
    for (int c = 0; c < CH; c++) begin
      per[c] = 0;
      phase[c] = 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a, h, h2, ge;
    set_idle();
    hist.push_back('0);

    // Reset: all outputs zero.
    repeat (3) step();
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_vld", longint'(vld), 0);
    check_eq("rst_ch", longint'(rch), 0);
    check_eq("rst_cnt", longint'(rcnt), 0);
    check_eq("rst_ovf", longint'(ovf), 0);
    rst_n = 1'b1;
    repeat (6) step();
    en = 1'b1;
    step();

    // Channel 0 at period 4, gate 100: 25 edges, other channels 0.
    per[0] = 4; phase[0] = 1;
    start_meas(100, a);
    run_group(a, 100, -1, 1'b0, 1'b0, 0, h);

    // Saturation: 300 edges into an 8-bit counter, then an idle measurement.
    set_idle(); per[1] = 2;
    start_meas(600, a);
    run_group(a, 600, -1, 1'b0, 1'b0, 0, h);
    set_idle();
    repeat (5) step();
    start_meas(40, a);
    run_group(a, 40, -1, 1'b0, 1'b0, 0, h);

    // Gate 0 behaves as gate 1 with channel 2 toggling randomly.
    per[2] = 1;
    for (int r = 0; r < 3; r++) begin
      start_meas(0, a);
      run_group(a, 0, -1, 1'b0, 1'b0, 0, h);
      step();
    end

    // Ready held low for 10 cycles on channel 1.
    for (int c = 0; c < CH; c++) begin
      per[c] = $urandom_range(1, 7);
      phase[c] = $urandom_range(0, 6);
    end
    start_meas(30, a);
    run_group(a, 30, 1, 1'b0, 1'b0, 0, h);

    // Continuous mode: three back-to-back groups, continuous cleared in the last.
    set_idle(); per[3] = 5; cont = 1'b1;
    start_meas(50, a);
    run_group(a, 50, -1, 1'b0, 1'b1, 50, h);
    run_group(h, 50, -1, 1'b0, 1'b1, 50, h2);
    run_group(h2, 50, 2, 1'b0, 1'b0, 50, h);
    step();
    check_eq("cont_idle", longint'(busy), 0);

    // Enable dropped mid-measure, then enable=0 beats a simultaneous start.
    for (int c = 0; c < CH; c++) per[c] = $urandom_range(1, 5);
    start_meas(100, a);
    repeat (30) step();
    en = 1'b0;
    step();
    check_eq("abort_busy", longint'(busy), 0);
    check_eq("abort_vld", longint'(vld), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("en0_start_busy", longint'(busy), 0);
    en = 1'b1;
    repeat (3) step();
    start_meas(40, a);
    run_group(a, 40, -1, 1'b0, 1'b0, 0, h);

    // Reset asserted mid-drain, then a fresh measurement.
    set_idle(); per[0] = 3;
    start_meas(20, a);
    while (cyc < a + 20) step();
    step();
    rdy = 1'b1;
    check_eq("pre_rst_vld", longint'(vld), 1);
    step();
    rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_drain_vld", longint'(vld), 0);
    check_eq("rst_drain_busy", longint'(busy), 0);
    set_idle();
    step();
    check_eq("rst_drain_vld2", longint'(vld), 0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    per[0] = 3; per[2] = 4;
    start_meas(20, a);
    run_group(a, 20, -1, 1'b0, 1'b0, 0, h);

    // Randomized measurements with stray starts while busy.
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < CH; c++) begin
        per[c] = $urandom_range(0, 7);
        phase[c] = $urandom_range(0, 6);
      end
      ge = $urandom_range(0, 60);
      start_meas(ge, a);
      run_group(a, ge, $urandom_range(0, 4), 1'b1, 1'b0, 0, h);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
